// File: rtl/led_pattern_sequencer.sv
// Avalon-MM LED sequencer: holds a static LED value or steps through a small
// pattern RAM at a programmable rate, looping or one-shot with a done interrupt.
module led_pattern_sequencer #(
  parameter int LED_W      = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int PRESC_W    = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [LED_W-1:0]  out_port,
  output logic              irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [PRESC_W-1:0]    CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] STEP_ONE = 1;

  logic [1:0]            state;
  logic [3:0]            ctrl;
  logic [LED_W-1:0]      static_val;
  logic [PRESC_W-1:0]    prescale;
  logic [PRESC_W-1:0]    count;
  logic [DEPTH_LOG2-1:0] pat_len;
  logic [DEPTH_LOG2-1:0] pat_ptr;
  logic [DEPTH_LOG2-1:0] step;
  logic                  done;
  logic [LED_W-1:0]      ram [2**DEPTH_LOG2];

  logic wr, wr_ctrl, wr_static, wr_presc, wr_len, wr_ptr, wr_data, wr_status;
  logic go, tick, step_last, set_done, running;
  logic [DEPTH_LOG2-1:0] step_next;
  logic unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr && (address == 3'd0);
  assign wr_static = wr && (address == 3'd1);
  assign wr_presc  = wr && (address == 3'd2);
  assign wr_len    = wr && (address == 3'd3);
  assign wr_ptr    = wr && (address == 3'd4);
  assign wr_data   = wr && (address == 3'd5);
  assign wr_status = wr && (address == 3'd6);

  assign go        = writedata[0] & writedata[1];
  assign tick      = (count == '0);
  // >= so that shrinking PAT_LEN below the current step still terminates the pass
  assign step_last = (step >= pat_len);
  assign step_next = step + STEP_ONE;
  assign running   = (state == ST_RUN);
  assign set_done  = running && !wr_ctrl && !wr_presc && tick && step_last && ctrl[2];
  assign unused_wd = ^writedata[31:PRESC_W];

  always_ff @(posedge clk) begin
    if (wr_data) ram[pat_ptr] <= writedata[LED_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ctrl       <= '0;
      static_val <= '0;
      prescale   <= '0;
      count      <= '0;
      pat_len    <= '0;
      pat_ptr    <= '0;
      step       <= '0;
      done       <= 1'b0;
      irq        <= 1'b0;
      out_port   <= '0;
    end else begin
      if (wr_ctrl)   ctrl       <= writedata[3:0];
      if (wr_static) static_val <= writedata[LED_W-1:0];
      if (wr_presc)  prescale   <= writedata[PRESC_W-1:0];
      if (wr_len)    pat_len    <= writedata[DEPTH_LOG2-1:0];
      if (wr_ptr)       pat_ptr <= writedata[DEPTH_LOG2-1:0];
      else if (wr_data) pat_ptr <= pat_ptr + STEP_ONE;

      // a set in the same cycle as a software clear wins
      if (set_done)                       done <= 1'b1;
      else if (wr_status && writedata[1]) done <= 1'b0;
      irq <= done & ctrl[3];

      if (wr_ctrl && !go) begin
        state    <= ST_IDLE;
        out_port <= static_val;
      end else if (wr_ctrl) begin
        state    <= ST_RUN;
        step     <= '0;
        count    <= prescale;
        out_port <= ram[0];
      end else begin
        case (state)
          ST_IDLE: out_port <= wr_static ? writedata[LED_W-1:0] : static_val;
          ST_RUN: begin
            // a PRESCALE write restarts the dwell of the current step
            if (wr_presc) begin
              count <= writedata[PRESC_W-1:0];
            end else if (tick) begin
              count <= prescale;
              if (!step_last) begin
                step     <= step_next;
                out_port <= ram[step_next];
              end else if (!ctrl[2]) begin
                step     <= '0;
                out_port <= ram[0];
              end else begin
                state <= ST_DONE;
              end
            end else begin
              count <= count - CNT_ONE;
            end
          end
          ST_DONE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        3'd0: readdata[3:0]            = ctrl;
        3'd1: readdata[LED_W-1:0]      = static_val;
        3'd2: readdata[PRESC_W-1:0]    = prescale;
        3'd3: readdata[DEPTH_LOG2-1:0] = pat_len;
        3'd4: readdata[DEPTH_LOG2-1:0] = pat_ptr;
        3'd6: begin
          readdata[0]              = running;
          readdata[1]              = done;
          readdata[4 +: DEPTH_LOG2] = step;
        end
        default: readdata = '0;
      endcase
    end
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Avalon-MM slave that drives the 8-bit board LED bank, replacing direct CPU writes to the LED PIO. In static mode it holds a CPU-written value. In pattern mode it autonomously steps through a 16-entry pattern RAM at a programmable rate, looping or one-shot, with a done interrupt. Zero-wait-state reads and writes, same clock domain as the Nios II data master.

Parameters:
LED_W, 8, LED output width
DEPTH_LOG2, 4, log2 of pattern RAM depth (16 entries)
PRESC_W, 24, prescaler width

Ports:
clk  in  1  system clock
reset_n  in  1  reset
address  in  3  register select (word address)
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  combinational read data, zero-extended
out_port  out  LED_W  LED drive, registered
irq  out  1  level interrupt, done flag AND irq_en

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk.
- Reset values: out_port=0, irq=0, state=IDLE, all registers 0, pattern RAM contents undefined (not reset).
- Write = chipselect & ~write_n; registers update on the next clk edge. Read = chipselect; readdata is a combinational mux of address, and unmapped addresses read 0.
- Register map:
  - 0 CTRL rw: [0] enable, [1] pattern_mode, [2] oneshot, [3] irq_en.
  - 1 STATIC rw: [7:0] LED value used when not running.
  - 2 PRESCALE rw: [23:0]; each step lasts PRESCALE+1 clocks.
  - 3 PAT_LEN rw: [3:0] last step index (steps = PAT_LEN+1).
  - 4 PAT_PTR rw: [3:0] pattern RAM write pointer.
  - 5 PAT_DATA wo: writes RAM[PAT_PTR]=writedata[7:0], then PAT_PTR+=1, wrapping 15->0. Reads as 0.
  - 6 STATUS: reads [0] running, [1] done, [7:4] current step. Writing with bit1=1 clears done; other bits ignored.
- FSM states: IDLE, RUN, DONE.
  - IDLE: out_port=STATIC, updated the cycle after a STATIC write.
    - CTRL write with enable=1 & pattern_mode=1 -> RUN. In the same edge: step=0, out_port=RAM[0], prescale count=PRESCALE.
  - RUN: count decrements each clk.
    - At count==0, if step<PAT_LEN: step+=1, out_port=RAM[step+1], count reloaded.
    - At count==0, if step==PAT_LEN and oneshot=0: step=0, out_port=RAM[0], reload.
    - At count==0, if step==PAT_LEN and oneshot=1: -> DONE, done=1, out_port holds the last entry.
  - DONE: out_port holds. A CTRL write with enable=1 & pattern_mode=1 restarts as from IDLE; done is not auto-cleared.
  - Any state, CTRL write with enable=0 or pattern_mode=0 -> IDLE next edge, out_port=STATIC. This takes priority over a step event in the same cycle.
- Mid-run writes:
  - PRESCALE write in RUN: count reloads with the new value on the same edge; the current step restarts its dwell.
  - PAT_LEN write below the current step: the next step event wraps to 0 (loop) or enters DONE (oneshot); the comparison is step>=PAT_LEN.
  - PAT_DATA write to the entry currently displayed: out_port does not change until that entry is next loaded.
  - CTRL write with enable=1 in RUN: restarts from step 0.
- Done flag: set-and-clear in the same cycle resolves as set.
- irq is registered and follows done&irq_en with 1-cycle latency.
- PRESCALE=0 steps every clock. PAT_LEN=0 repeats RAM[0].
- Reset mid-run: immediate IDLE, out_port=0.

Test Plan:
- Static path: reset, write STATIC=0xA5 -> out_port=0x00 during reset, 0xA5 one clock after the write; read STATUS -> 0x00.
- Loop run: RAM={01,02,04,08}, PAT_LEN=3, PRESCALE=2, CTRL=0x3 -> out_port 01,02,04,08,01..., each held exactly 3 clocks; STATUS[7:4] tracks 0..3.
- Oneshot + irq: same RAM, CTRL=0xF -> after 12 clocks out_port holds 0x08, STATUS=0x32, irq=1 next clock; write STATUS=0x2 -> irq=0, out_port still 0x08.
- Pointer wrap: PAT_PTR=15, write PAT_DATA 0x11 then 0x22 -> RAM[15]=0x11, RAM[0]=0x22, PAT_PTR reads 1.
- Abort/priority: in RUN with PRESCALE=0, write CTRL=0x0 on a step edge -> out_port=STATIC next clock, no further steps, running=0.
- Async reset mid-run: assert reset_n low between clock edges -> out_port=0 and irq=0 immediately; after release, state is IDLE.
